// File: rtl/axis_rr_arbiter_if.sv
// Shared data-width package and the AXI-Stream interface used by the arbiter's downstream port.
package axis_fifo_pkg_prm;
    parameter int AXI_DATA_WIDTH = 32;
endpackage

interface axis_if;
    logic [axis_fifo_pkg_prm::AXI_DATA_WIDTH-1:0] tdata;
    logic                                         tvalid;
    logic                                         tready;

    modport m_axis (output tdata, output tvalid, input tready);
    modport s_axis (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC AXI-Stream requesters onto one downstream stream,
// with bursts capped at MAX_BURST beats per grant.
//
// state | meaning
// IDLE  | no owner; pick next requester after last_grant, outputs quiet
// GRANT | source 'grant' owns the stream until MAX_BURST beats or its valid drops
module axis_rr_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                                                        aclk,
    input  logic                                                        aresetn,
    input  logic [NUM_SRC-1:0][axis_fifo_pkg_prm::AXI_DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]                                          s_tvalid,
    output logic [NUM_SRC-1:0]                                          s_tready,
    axis_if.m_axis                                                      m_axis,
    output logic [$clog2(NUM_SRC)-1:0]                                  grant,
    output logic                                                        busy
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = $clog2(MAX_BURST + 1);

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("axis_rr_arbiter: NUM_SRC must be within 2..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("axis_rr_arbiter: MAX_BURST must be within 1..256");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [CW-1:0]   beat_cnt;
    logic [GW-1:0]   next_grant;
    int              idx;

    // Walk downward so the nearest requester after last_grant is the final (winning) assignment.
    always_comb begin
        next_grant = last_grant;
        idx        = 0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_SRC;
            if (s_tvalid[GW'(idx)]) begin
                next_grant = GW'(idx);
            end
        end
    end

    always_comb begin
        m_axis.tdata  = s_tdata[grant];
        m_axis.tvalid = 1'b0;
        s_tready      = '0;
        if (state == GRANT) begin
            m_axis.tvalid   = s_tvalid[grant];
            s_tready[grant] = m_axis.tready;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_SRC - 1);
            beat_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_tvalid) begin
                        state    <= GRANT;
                        grant    <= next_grant;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    // A requester that drops valid gives up the rest of its burst.
                    if (!s_tvalid[grant]) begin
                        state      <= IDLE;
                        beat_cnt   <= '0;
                        last_grant <= grant;
                        busy       <= 1'b0;
                    end else if (m_axis.tready) begin
                        if (beat_cnt == CW'(MAX_BURST - 1)) begin
                            state      <= IDLE;
                            beat_cnt   <= '0;
                            last_grant <= grant;
                            busy       <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: a 4-source/4-beat instance plus a 2-source/1-beat instance.
module tb_axis_rr_arbiter;

    localparam int W = axis_fifo_pkg_prm::AXI_DATA_WIDTH;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [3:0][W-1:0] s_tdata;
    logic [3:0]        s_tvalid;
    logic [3:0]        s_tready;
    logic [1:0]        grant;
    logic              busy;
    axis_if            m_if ();

    logic [1:0][W-1:0] s1_tdata;
    logic [1:0]        s1_tvalid;
    logic [1:0]        s1_tready;
    logic              grant1;
    logic              busy1;
    axis_if            m1_if ();

    axis_rr_arbiter #(.NUM_SRC(4), .MAX_BURST(4)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_axis   (m_if),
        .grant    (grant),
        .busy     (busy)
    );

    axis_rr_arbiter #(.NUM_SRC(2), .MAX_BURST(1)) dut1 (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s1_tdata),
        .s_tvalid (s1_tvalid),
        .s_tready (s1_tready),
        .m_axis   (m1_if),
        .grant    (grant1),
        .busy     (busy1)
    );

    typedef struct packed {
        logic [1:0]   src;
        logic [W-1:0] data;
    } beat_t;

    beat_t sb_q[$];
    int    len_q[$];
    int    seq[4];
    int    exp_seq[4];
    int    tests = 0;
    int    fails = 0;
    int    hs_total = 0;
    int    cur_len = 0;
    bit    prev_stall = 0;
    bit    prev_busy = 0;
    bit    rand_ready = 0;
    logic [W-1:0] prev_data;

    function automatic logic [W-1:0] src_data(int s, int n);
        return W'((s << 16) | (n & 'hFFFF));
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) s_tdata[i] = src_data(i, seq[i]);
    end

    task automatic check_val(string tag, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_burst(int src, int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.src  = 2'(src);
            b.data = src_data(src, exp_seq[src]);
            sb_q.push_back(b);
            exp_seq[src]++;
        end
    endtask

    // One clock: monitor at negedge, then advance sources and drive ready just after posedge.
    task automatic step();
        logic [3:0] hs;
        beat_t      b;
        @(negedge aclk);
        if (prev_stall) begin
            check_val("hold_data", m_if.tdata, prev_data);
            check_val("hold_valid", m_if.tvalid, 1);
        end
        check_val("sready_other", s_tready & ~(4'b0001 << grant), 0);
        hs = s_tvalid & s_tready;
        if (m_if.tvalid && m_if.tready) begin
            hs_total++;
            cur_len++;
            check_val("sb_avail", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                b = sb_q.pop_front();
                check_val("beat_src", grant, b.src);
                check_val("beat_data", m_if.tdata, b.data);
            end
        end
        if (prev_busy && !busy) begin
            len_q.push_back(cur_len);
            cur_len = 0;
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_data  = m_if.tdata;
        prev_busy  = busy;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) seq[i]++;
        if (rand_ready) m_if.tready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_beats(logic [3:0] mask, int n, int budget, bit drop);
        int start;
        int cnt;
        s_tvalid = mask;
        start = hs_total;
        cnt = 0;
        while ((hs_total - start) < n && cnt < budget) begin
            step();
            cnt++;
        end
        check_val("beats_done", hs_total - start, n);
        if (drop) begin
            s_tvalid = '0;
            step();
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            exp_seq[i] = 0;
        end
        s_tvalid    = 4'hF;
        m_if.tready = 1'b1;
        s1_tvalid   = 2'b00;
        s1_tdata[0] = W'(32'hA0);
        s1_tdata[1] = W'(32'hA1);
        m1_if.tready = 1'b1;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_tvalid", m_if.tvalid, 0);
        check_val("rst_sready", s_tready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_grant", grant, 0);

        // All four valid from reset release: grants 0,1,2,3,0 with one idle cycle each.
        push_burst(0, 4); push_burst(1, 4); push_burst(2, 4); push_burst(3, 4); push_burst(0, 4);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            check_val("s1_busy", busy, (cyc % 5) != 0);
            if ((cyc % 5) != 0) check_val("s1_grant", grant, (cyc / 5) % 4);
            step();
        end
        s_tvalid = '0;
        step();
        check_val("s1_drain", sb_q.size(), 0);

        // Single requester 2 for ten beats: bursts 4,4,2.
        len_q.delete();
        cur_len = 0;
        push_burst(2, 10);
        run_beats(4'b0100, 10, 60, 1);
        check_val("s2_nbursts", len_q.size(), 3);
        if (len_q.size() == 3) begin
            check_val("s2_len0", len_q[0], 4);
            check_val("s2_len1", len_q[1], 4);
            check_val("s2_len2", len_q[2], 2);
        end
        check_val("s2_drain", sb_q.size(), 0);

        // Random backpressure with sources 1 and 3; search resumes after 2, so 3 goes first.
        len_q.delete();
        cur_len = 0;
        for (int k = 0; k < 3; k++) begin
            push_burst(3, 4);
            push_burst(1, 4);
        end
        rand_ready = 1;
        run_beats(4'b1010, 24, 400, 1);
        rand_ready = 0;
        m_if.tready = 1'b1;
        check_val("s3_nbursts", len_q.size(), 6);
        foreach (len_q[k]) check_val("s3_len", len_q[k], 4);
        check_val("s3_drain", sb_q.size(), 0);

        // Wrap: leave last_grant at 3, then 1001 must pick 0 and 1000 must pick 3.
        push_burst(3, 1);
        run_beats(4'b1000, 1, 20, 1);
        push_burst(0, 1);
        run_beats(4'b1001, 1, 20, 1);
        check_val("s4_wrap", grant, 0);
        push_burst(3, 1);
        run_beats(4'b1000, 1, 20, 1);
        check_val("s4_skip", grant, 3);

        // Reset pulse after beat 2 of source 1's burst.
        len_q.delete();
        cur_len = 0;
        push_burst(1, 2);
        run_beats(4'b0010, 2, 20, 0);
        check_val("s5_busy_pre", busy, 1);
        aresetn = 1'b0;
        #1;
        check_val("s5_tvalid", m_if.tvalid, 0);
        check_val("s5_sready", s_tready, 0);
        check_val("s5_busy", busy, 0);
        check_val("s5_grant", grant, 0);
        s_tvalid = 4'hF;
        step();
        aresetn = 1'b1;
        check_val("s5_abort_len", (len_q.size() > 0) ? len_q[0] : 99, 2);
        push_burst(0, 4);
        run_beats(4'hF, 4, 40, 1);
        check_val("s5_drain", sb_q.size(), 0);

        // MAX_BURST=1 with two requesters: one beat per grant, alternating every two cycles.
        s1_tvalid = 2'b11;
        for (int cyc = 0; cyc < 12; cyc++) begin
            check_val("s6_busy", busy1, cyc % 2);
            if ((cyc % 2) == 1) begin
                check_val("s6_grant", grant1, (cyc / 2) % 2);
                check_val("s6_tvalid", m1_if.tvalid, 1);
                check_val("s6_data", m1_if.tdata, 32'hA0 + (cyc / 2) % 2);
                check_val("s6_sready", s1_tready, 2'b01 << ((cyc / 2) % 2));
            end
            step();
        end
        s1_tvalid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
